mem_arbiter: RTL and testbench

Shares the single-port program/data memory between three requesters: the program loader (port 0), the CPU data-memory port (port 1) and the CPU instruction-fetch port (port 2). Fixed priority for the loader; round-robin between data and fetch. Each access is captured, issued to memory and, for reads, completed with a one-cycle rvalid pulse after the memory read latency. Sits between the cpu core/loader and the memory macro.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between three requesters.
//   Port 0 = program loader (fixed highest priority)
//   Port 1 = CPU data port, port 2 = CPU fetch port (round-robin between them)
// Each access is captured in IDLE, issued for one cycle in ISSUE, and reads
// then wait MEM_LAT cycles in WAIT before a one-cycle rvalid pulse.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   req/we [2:0]        per-port request and write enable (bit i = port i)
//   addr, wdata         packed per-port address / write data
//   gnt, rvalid [2:0]   one-hot pulses: access issued / read data valid
//   rdata               shared read data, holds last value between pulses
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory macro interface
//   busy                high while an access is in flight (not IDLE)
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_LAT    = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [2:0]              req,
    input  logic [2:0]              we,
    input  logic [3*ADDR_WIDTH-1:0] addr,
    input  logic [3*DATA_WIDTH-1:0] wdata,
    output logic [2:0]              gnt,
    output logic [2:0]              rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

    state_t                  state_reg, state_next;
    logic [1:0]              win_reg, win_next;
    logic                    cap_we_reg, cap_we_next;
    logic [ADDR_WIDTH-1:0]   cap_addr_reg, cap_addr_next;
    logic [DATA_WIDTH-1:0]   cap_wdata_reg, cap_wdata_next;
    logic [2:0]              cnt_reg, cnt_next;
    // rr_reg = 1 means port 2 wins the next 1-vs-2 tie (port 1 was served last)
    logic                    rr_reg, rr_next;
    logic [2:0]              rvalid_reg, rvalid_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;

    logic [ADDR_WIDTH-1:0]   port_addr  [3];
    logic [DATA_WIDTH-1:0]   port_wdata [3];
    logic [1:0]              sel;
    logic [2:0]              win_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_port
            assign port_addr[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign port_wdata[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Arbitration: loader first, then whichever CPU port is favoured on a tie.
    always_comb begin
        sel = 2'd0;
        if (req[0])
            sel = 2'd0;
        else if (req[1] && req[2])
            sel = rr_reg ? 2'd2 : 2'd1;
        else if (req[1])
            sel = 2'd1;
        else
            sel = 2'd2;
    end

    assign win_onehot = 3'b001 << win_reg;

    always_comb begin
        state_next     = state_reg;
        win_next       = win_reg;
        cap_we_next    = cap_we_reg;
        cap_addr_next  = cap_addr_reg;
        cap_wdata_next = cap_wdata_reg;
        cnt_next       = cnt_reg;
        rr_next        = rr_reg;
        rvalid_next    = 3'b000;
        rdata_next     = rdata_reg;
        gnt            = 3'b000;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    win_next       = sel;
                    cap_we_next    = we[sel];
                    cap_addr_next  = port_addr[sel];
                    cap_wdata_next = port_wdata[sel];
                    // Loader wins leave the CPU round-robin untouched.
                    if (sel != 2'd0)
                        rr_next = (sel == 2'd1);
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en = 1'b1;
                mem_we = cap_we_reg;
                gnt    = win_onehot;
                if (cap_we_reg) begin
                    state_next = IDLE;
                end else begin
                    cnt_next   = LAT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Count of 1 marks the cycle in which mem_rdata is valid.
                if (cnt_reg == 3'd1) begin
                    rdata_next  = mem_rdata;
                    rvalid_next = win_onehot;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            win_reg       <= 2'd0;
            cap_we_reg    <= 1'b0;
            cap_addr_reg  <= '0;
            cap_wdata_reg <= '0;
            cnt_reg       <= 3'd0;
            rr_reg        <= 1'b0;
            rvalid_reg    <= 3'b000;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            win_reg       <= win_next;
            cap_we_reg    <= cap_we_next;
            cap_addr_reg  <= cap_addr_next;
            cap_wdata_reg <= cap_wdata_next;
            cnt_reg       <= cnt_next;
            rr_reg        <= rr_next;
            rvalid_reg    <= rvalid_next;
            rdata_reg     <= rdata_next;
        end
    end

    assign mem_addr  = cap_addr_reg;
    assign mem_wdata = cap_wdata_reg;
    assign rvalid    = rvalid_reg;
    assign rdata     = rdata_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: random requester agents, a memory
// macro model, and a negedge monitor that checks every cycle against a
// transaction-level reference (priority/round-robin winner, memory contents,
// read completion time).
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic [2:0]    req, we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]    gnt, rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 5) return 16'hBEEF;
        return DW'(a * 16'h0101) ^ 16'h5A5A;
    endfunction

    // ---------------- memory macro model (LAT-cycle read pipeline) --------
    logic [DW-1:0] mem_arr [0:255];
    logic [DW-1:0] pipe    [0:7];
    initial for (int i = 0; i < 256; i++) mem_arr[i] = init_val(i);
    always @(posedge CLK) begin
        if (mem_en && mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
        pipe[0] <= mem_arr[mem_addr[7:0]];
        for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    // ---------------- reference model + scoreboard ------------------------
    typedef struct { int port; logic [DW-1:0] data; int due; } rd_t;
    rd_t            exp_q [$];
    logic [DW-1:0]  ref_wr [int];

    function automatic logic [DW-1:0] ref_read(input int a);
        if (ref_wr.exists(a)) return ref_wr[a];
        return init_val(a);
    endfunction

    // Loader first; on a CPU tie, the port not served most recently.
    function automatic int pick(input logic [2:0] r, input int last);
        if (r[0]) return 0;
        if (r[1] && r[2]) return (last == 1) ? 2 : 1;
        return r[1] ? 1 : 2;
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, expv);
        end
    endtask

    int            cyc = 0;
    bit            armed = 0;
    bit            cur_idle = 1, nxt_idle;
    bit            exp_gnt = 0, exp_gnt_n;
    int            rr_last = 2;
    logic [2:0]    req_prev = '0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata, last_rdata;

    always @(negedge CLK) begin
        int w;
        cyc++;
        if (RST === 1'b1) begin
            armed = 1; exp_q.delete(); nxt_idle = 1; exp_gnt_n = 0; rr_last = 2;
            last_addr = '0; last_wdata = '0; last_rdata = '0;
        end else if (armed) begin
            chk("busy", cyc, 32'(busy), 32'(!cur_idle));
            nxt_idle = cur_idle; exp_gnt_n = 0;
            if (exp_gnt) begin
                w = pick(req_prev, rr_last);
                chk("gnt", cyc, 32'(gnt), 32'(3'b001 << w));
                chk("mem_en", cyc, 32'(mem_en), 1);
                chk("mem_we", cyc, 32'(mem_we), 32'(we[w]));
                chk("mem_addr", cyc, 32'(mem_addr), 32'(addr[w*AW +: AW]));
                chk("mem_wdata", cyc, 32'(mem_wdata), 32'(wdata[w*DW +: DW]));
                last_addr  = addr[w*AW +: AW];
                last_wdata = wdata[w*DW +: DW];
                if (w != 0) rr_last = w;
                if (we[w]) begin
                    ref_wr[int'(last_addr)] = last_wdata;
                    nxt_idle = 1;
                end else begin
                    exp_q.push_back('{port: w, data: ref_read(int'(last_addr)), due: cyc + LAT + 1});
                    nxt_idle = 0;
                end
            end else begin
                chk("gnt_quiet", cyc, 32'(gnt), 0);
                chk("mem_en_quiet", cyc, 32'({mem_en, mem_we}), 0);
                chk("mem_addr_hold", cyc, 32'(mem_addr), 32'(last_addr));
                chk("mem_wdata_hold", cyc, 32'(mem_wdata), 32'(last_wdata));
                if (cur_idle) begin
                    exp_gnt_n = (req != 3'b000);
                    nxt_idle  = (req == 3'b000);
                end else begin
                    nxt_idle = (exp_q.size() > 0) && (exp_q[0].due == cyc + 1);
                end
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("rvalid", cyc, 32'(rvalid), 32'(3'b001 << exp_q[0].port));
                chk("rdata", cyc, 32'(rdata), 32'(exp_q[0].data));
                $display("read done cyc=%0d port=%0d data=%h", cyc, exp_q[0].port, rdata);
                last_rdata = exp_q[0].data;
                void'(exp_q.pop_front());
            end else begin
                chk("rvalid_quiet", cyc, 32'(rvalid), 0);
                chk("rdata_hold", cyc, 32'(rdata), 32'(last_rdata));
            end
        end
        cur_idle = nxt_idle;
        exp_gnt  = exp_gnt_n;
        req_prev = req;
    end

    // ---------------- stimulus ---------------------------------------------
    // One cycle of requester behaviour: a port may change its request only
    // when idle or right after being granted.
    task automatic tick(input logic [2:0] mask, input int load, input int wpct);
        logic [2:0] g;
        @(negedge CLK);
        g = gnt;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (!req[i] || g[i]) begin
                if (mask[i] && ($urandom_range(99) < load)) begin
                    req[i]            = 1'b1;
                    we[i]             = ($urandom_range(99) < wpct);
                    addr[i*AW +: AW]  = AW'($urandom_range(31));
                    wdata[i*DW +: DW] = DW'($urandom);
                end else begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int n);
        req[p] = 1'b1; we[p] = w; addr[p*AW +: AW] = a; wdata[p*DW +: DW] = d;
        repeat (n) tick(3'b000, 0, 0);
    endtask

    task automatic do_reset();
        RST = 1'b1; req = '0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (10) tick(3'b000, 0, 0);
        issue(2, 1'b0, 16'h0005, 16'h0000, 8);     // read 0xBEEF
        issue(1, 1'b1, 16'h0010, 16'h1234, 4);     // write
        issue(2, 1'b0, 16'h0010, 16'h0000, 8);     // read back 0x1234
        do_reset();
        repeat (60)  tick(3'b110, 100, 0);         // CPU ports alternate
        repeat (200) tick(3'b110, 100, 40);
        do_reset();
        repeat (40)  tick(3'b111, 100, 30);        // loader dominates
        repeat (40)  tick(3'b110, 100, 30);
        repeat (30)  tick(3'b000, 0, 0);
        // reset while a read sits in WAIT: the read must never complete
        req[2] = 1'b1; we[2] = 1'b0; addr[2*AW +: AW] = 16'h0003;
        repeat (2) tick(3'b000, 0, 0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (10)  tick(3'b000, 0, 0);
        repeat (300) tick(3'b111, 60, 40);
        repeat (30)  tick(3'b000, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
